// File: rtl/w_grf_pkg.sv
// Shared constants for the W stage: opcode/funct encodings, write-back source
// select and the link register index.
package w_grf_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_JAL    = 6'h03;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_JR  = 6'h08;

    localparam logic [4:0] REG_RA    = 5'd31;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC8 = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/w_grf_w_decoder.sv
// W-stage decoder: picks the destination register and write-back source of
// W_instr. Destination 0 means the instruction writes nothing.
module w_decoder
    import w_grf_pkg::*;
(
    input  logic [31:0] W_instr,
    output logic [4:0]  wb_addr,
    output wb_sel_e     wb_sel
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_fields;

    assign opcode        = W_instr[31:26];
    assign rt            = W_instr[20:16];
    assign rd            = W_instr[15:11];
    assign funct         = W_instr[5:0];
    assign unused_fields = ^{W_instr[25:21], W_instr[10:6]};

    always_comb begin
        wb_addr = 5'd0;
        wb_sel  = WB_ALU;
        case (opcode)
            OP_RTYPE: begin
                // jr and the all-zero nop fall through here with no write
                if (funct == FUNCT_ADD || funct == FUNCT_SUB) begin
                    wb_addr = rd;
                end
            end
            OP_ORI, OP_LUI: wb_addr = rt;
            OP_LW: begin
                wb_addr = rt;
                wb_sel  = WB_MEM;
            end
            OP_JAL: begin
                wb_addr = REG_RA;
                wb_sel  = WB_PC8;
            end
            OP_SW, OP_BEQ: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/w_grf.sv
// Write-back stage and 32x32 general register file with retire counter.
// Define GRF_BYPASS_EN for write-first reads of the register being written.
module w_grf
    import w_grf_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 W_stall,
    input  logic [31:0]          W_instr,
    input  logic [31:0]          W_PC8,
    input  logic [31:0]          W_ALU_result,
    input  logic [31:0]          W_MEM_read_data,
    input  logic [4:0]           D_rs_addr,
    input  logic [4:0]           D_rt_addr,
    output logic [31:0]          D_rs_data,
    output logic [31:0]          D_rt_data,
    output logic [4:0]           W_fwd_addr,
    output logic [31:0]          W_fwd_data,
    output logic [INSTRET_W-1:0] instret
);

    wb_sel_e               wb_sel;
    logic                  we;
    logic [31:0]           regs_q [32];
    logic [INSTRET_W-1:0]  instret_q;

    w_decoder u_w_decoder (
        .W_instr (W_instr),
        .wb_addr (W_fwd_addr),
        .wb_sel  (wb_sel)
    );

    always_comb begin
        W_fwd_data = W_ALU_result;
        case (wb_sel)
            WB_ALU:  W_fwd_data = W_ALU_result;
            WB_MEM:  W_fwd_data = W_MEM_read_data;
            WB_PC8:  W_fwd_data = W_PC8;
            default: W_fwd_data = W_ALU_result;
        endcase
    end

    // A zero destination never enables, so $0 is never written and reads 0.
    assign we = (W_fwd_addr != 5'd0) && !W_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we) begin
            regs_q[W_fwd_addr] <= W_fwd_data;
        end
    end

`ifdef GRF_BYPASS_EN
    assign D_rs_data = (we && D_rs_addr == W_fwd_addr) ? W_fwd_data : regs_q[D_rs_addr];
    assign D_rt_data = (we && D_rt_addr == W_fwd_addr) ? W_fwd_data : regs_q[D_rt_addr];
`else
    assign D_rs_data = regs_q[D_rs_addr];
    assign D_rt_data = regs_q[D_rt_addr];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (W_instr != 32'd0 && !W_stall) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_w_grf.sv
// Directed self-checking bench for w_grf; a 4-bit-counter instance covers wrap.
module tb_w_grf;

`ifdef GRF_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        W_stall;
    logic [31:0] W_instr;
    logic [31:0] W_PC8;
    logic [31:0] W_ALU_result;
    logic [31:0] W_MEM_read_data;
    logic [4:0]  D_rs_addr;
    logic [4:0]  D_rt_addr;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic [4:0]  W_fwd_addr;
    logic [31:0] W_fwd_data;
    logic [31:0] instret;

    logic [31:0] d_rs_data_unused;
    logic [31:0] d_rt_data_unused;
    logic [4:0]  fwd_addr_unused;
    logic [31:0] fwd_data_unused;
    logic [3:0]  instret4;

    int n_tests = 0;
    int n_fail  = 0;

    w_grf #(.INSTRET_W(32)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .W_stall         (W_stall),
        .W_instr         (W_instr),
        .W_PC8           (W_PC8),
        .W_ALU_result    (W_ALU_result),
        .W_MEM_read_data (W_MEM_read_data),
        .D_rs_addr       (D_rs_addr),
        .D_rt_addr       (D_rt_addr),
        .D_rs_data       (D_rs_data),
        .D_rt_data       (D_rt_data),
        .W_fwd_addr      (W_fwd_addr),
        .W_fwd_data      (W_fwd_data),
        .instret         (instret)
    );

    w_grf #(.INSTRET_W(4)) u_dut4 (
        .clk             (clk),
        .reset           (reset),
        .W_stall         (W_stall),
        .W_instr         (W_instr),
        .W_PC8           (W_PC8),
        .W_ALU_result    (W_ALU_result),
        .W_MEM_read_data (W_MEM_read_data),
        .D_rs_addr       (D_rs_addr),
        .D_rt_addr       (D_rt_addr),
        .D_rs_data       (d_rs_data_unused),
        .D_rt_data       (d_rt_data_unused),
        .W_fwd_addr      (fwd_addr_unused),
        .W_fwd_data      (fwd_data_unused),
        .instret         (instret4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [31:0] no_write [5];

    initial begin
        reset           = 1'b0;
        W_stall         = 1'b0;
        W_instr         = 32'd0;
        W_PC8           = 32'd0;
        W_ALU_result    = 32'd0;
        W_MEM_read_data = 32'd0;
        D_rs_addr       = 5'd0;
        D_rt_addr       = 5'd0;

        #2;
        check_eq("reset_rs_data", D_rs_data, 32'd0);
        check_eq("reset_instret", instret, 32'd0);
        check_eq("reset_fwd_addr", 32'(W_fwd_addr), 32'd0);
        reset = 1'b1;
        step();

        // ori $5,$0,0x1234
        W_instr      = enc_i(6'h0d, 5'd0, 5'd5, 16'h1234);
        W_ALU_result = 32'h0000_1234;
        D_rs_addr    = 5'd5;
        #1;
        check_eq("ori_fwd_addr", 32'(W_fwd_addr), 32'd5);
        check_eq("ori_fwd_data", W_fwd_data, 32'h0000_1234);
        check_eq("ori_same_cycle", D_rs_data, Bypass ? 32'h0000_1234 : 32'd0);
        step();
        W_instr = 32'd0;
        #1;
        check_eq("ori_read", D_rs_data, 32'h0000_1234);
        check_eq("ori_instret", instret, 32'd1);

        // lw $7 picks load data, not the address
        W_instr         = enc_i(6'h23, 5'd0, 5'd7, 16'h0010);
        W_ALU_result    = 32'h0000_0010;
        W_MEM_read_data = 32'hDEAD_BEEF;
        D_rt_addr       = 5'd7;
        #1;
        check_eq("lw_fwd_data", W_fwd_data, 32'hDEAD_BEEF);
        step();
        W_instr = 32'd0;
        #1;
        check_eq("lw_read", D_rt_data, 32'hDEAD_BEEF);
        check_eq("lw_instret", instret, 32'd2);

        // jal writes PC+8 to $31
        W_instr = {6'h03, 26'h000_0c02};
        W_PC8   = 32'h0000_3008;
        #1;
        check_eq("jal_fwd_addr", 32'(W_fwd_addr), 32'd31);
        check_eq("jal_fwd_data", W_fwd_data, 32'h0000_3008);
        step();
        W_instr   = 32'd0;
        D_rs_addr = 5'd31;
        #1;
        check_eq("jal_read", D_rs_data, 32'h0000_3008);
        check_eq("jal_instret", instret, 32'd3);

        // add $0,$1,$2 is dropped but still retires
        W_instr      = enc_r(5'd1, 5'd2, 5'd0, 6'h20);
        W_ALU_result = 32'h0000_FFFF;
        #1;
        check_eq("add0_fwd_addr", 32'(W_fwd_addr), 32'd0);
        step();
        W_instr   = 32'd0;
        D_rs_addr = 5'd0;
        #1;
        check_eq("add0_read_r0", D_rs_data, 32'd0);
        check_eq("add0_instret", instret, 32'd4);

        // add $3 = 0x55 read in the same cycle
        W_instr      = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        W_ALU_result = 32'h0000_0055;
        D_rt_addr    = 5'd3;
        #1;
        check_eq("add3_same_cycle", D_rt_data, Bypass ? 32'h0000_0055 : 32'd0);
        step();
        W_instr = 32'd0;
        #1;
        check_eq("add3_read", D_rt_data, 32'h0000_0055);
        check_eq("add3_instret", instret, 32'd5);

        // sub $4
        W_instr      = enc_r(5'd3, 5'd1, 5'd4, 6'h22);
        W_ALU_result = 32'h0000_0077;
        #1;
        check_eq("sub_fwd_addr", 32'(W_fwd_addr), 32'd4);
        step();
        W_instr   = 32'd0;
        D_rs_addr = 5'd4;
        #1;
        check_eq("sub_read", D_rs_data, 32'h0000_0077);
        check_eq("sub_instret", instret, 32'd6);

        // sw held by a 3-cycle stall retires exactly once
        W_instr      = enc_i(6'h2b, 5'd0, 5'd5, 16'h0000);
        W_ALU_result = 32'h0000_0099;
        W_stall      = 1'b1;
        D_rs_addr    = 5'd5;
        #1;
        check_eq("sw_fwd_addr", 32'(W_fwd_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("sw_stall_instret", instret, 32'd6);
            check_eq("sw_stall_r5", D_rs_data, 32'h0000_1234);
        end
        W_stall = 1'b0;
        step();
        W_instr = 32'd0;
        #1;
        check_eq("sw_release_instret", instret, 32'd7);
        step();
        check_eq("sw_once_instret", instret, 32'd7);

        // stalled ori $6 writes only after the stall drops
        W_instr      = enc_i(6'h0d, 5'd0, 5'd6, 16'h00aa);
        W_ALU_result = 32'h0000_00aa;
        W_stall      = 1'b1;
        D_rs_addr    = 5'd6;
        #1;
        check_eq("ori6_stall_bypass", D_rs_data, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("ori6_stall_r6", D_rs_data, 32'd0);
        end
        check_eq("ori6_stall_instret", instret, 32'd7);
        W_stall = 1'b0;
        #1;
        check_eq("ori6_release_same_cycle", D_rs_data, Bypass ? 32'h0000_00aa : 32'd0);
        step();
        W_instr = 32'd0;
        #1;
        check_eq("ori6_read", D_rs_data, 32'h0000_00aa);
        check_eq("ori6_instret", instret, 32'd8);

        // beq, jr, slt (unrecognised funct), unknown opcode, nop: no writes
        no_write[0] = enc_i(6'h04, 5'd5, 5'd5, 16'h0004);
        no_write[1] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
        no_write[2] = enc_r(5'd1, 5'd2, 5'd9, 6'h2a);
        no_write[3] = 32'hFC00_0000;
        no_write[4] = 32'd0;
        W_ALU_result = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            W_instr = no_write[i];
            #1;
            check_eq($sformatf("nowrite%0d_fwd_addr", i), 32'(W_fwd_addr), 32'd0);
            step();
        end
        W_instr   = 32'd0;
        D_rs_addr = 5'd9;
        D_rt_addr = 5'd5;
        #1;
        check_eq("nowrite_r9", D_rs_data, 32'd0);
        check_eq("nowrite_r5", D_rt_data, 32'h0000_1234);
        check_eq("nowrite_instret", instret, 32'd12);
        check_eq("nowrite_instret4", 32'(instret4), 32'hC);

        // asynchronous reset mid-run, with a write pending across an edge
        W_instr      = enc_i(6'h0d, 5'd0, 5'd9, 16'h0abc);
        W_ALU_result = 32'h0000_0abc;
        D_rs_addr    = 5'd5;
        D_rt_addr    = 5'd9;
        reset        = 1'b0;
        #1;
        check_eq("rst_async_r5", D_rs_data, 32'd0);
        check_eq("rst_async_instret", instret, 32'd0);
        check_eq("rst_async_instret4", 32'(instret4), 32'd0);
        step();
        check_eq("rst_hold_r9", D_rt_data, 32'd0);
        check_eq("rst_hold_instret", instret, 32'd0);
        reset = 1'b1;
        step();
        W_instr = 32'd0;
        #1;
        check_eq("post_rst_r9", D_rt_data, 32'h0000_0abc);
        check_eq("post_rst_instret", instret, 32'd1);

        // narrow counter reaches all-ones then wraps to 0
        W_instr      = enc_i(6'h0d, 5'd0, 5'd1, 16'h0001);
        W_ALU_result = 32'h0000_0001;
        for (int i = 0; i < 14; i++) begin
            step();
        end
        check_eq("wrap_pre_instret", instret, 32'd15);
        check_eq("wrap_pre_instret4", 32'(instret4), 32'hF);
        step();
        check_eq("wrap_instret4", 32'(instret4), 32'h0);
        check_eq("wrap_instret", instret, 32'd16);
        W_instr = 32'd0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
